// File: rtl/fib_pkg.sv
// Shared definitions for the bit-serial Fibonacci engine: default sizes,
// state encoding and the full-adder majority helper.
package fib_pkg;

  localparam int FIB_WIDTH = 8;
  localparam int FIB_NW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } fib_state_t;

  function automatic logic fib_maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fib_serial_fa.sv
// Registered 1-bit full adder: combinational sum, carry held in a flop and
// optionally cleared so the next addition starts with carry-in 0.
module fib_serial_fa
  import fib_pkg::*;
(
  input  logic clk,
  input  logic CLR,
  input  logic a,
  input  logic b,
  input  logic clr_carry,
  output logic sum,
  output logic carry
);

  logic carry_q;
  logic carry_d;

  always_comb begin
    sum     = a ^ b ^ carry_q;
    carry_d = clr_carry ? 1'b0 : fib_maj(a, b, carry_q);
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;

endmodule

// File: rtl/fib_serial_engine.sv
// Bit-serial Fibonacci sequencer: A=F(k-1) and B=F(k) are added LSB-first
// through one registered full adder, one bit per clock, until F(n) is formed.
module fib_serial_engine
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NW    = FIB_NW
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  fib_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NW-1:0]    k_q, k_d;
  logic [NW-1:0]    n_q, n_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_carry;
  logic last_bit;
  logic last_pass;
  logic clr_carry;

  assign last_bit  = (bit_cnt_q == CW'(WIDTH - 1));
  assign last_pass = ((k_q + NW'(1)) == n_q);
  // Carry must enter every pass at zero, including the first after IDLE.
  assign clr_carry = (state_q != ST_ADD) || last_bit;

  fib_serial_fa u_fa (
    .clk       (clk),
    .CLR       (CLR),
    .a         (a_q[0]),
    .b         (b_q[0]),
    .clr_carry (clr_carry),
    .sum       (fa_sum),
    .carry     (fa_carry)
  );

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      bit_cnt_q <= '0;
      k_q       <= '0;
      n_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      bit_cnt_q <= bit_cnt_d;
      k_q       <= k_d;
      n_q       <= n_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (n < NW'(2)) ? ST_DONE : ST_ADD;
        end
      end
      ST_ADD: begin
        if (last_bit && last_pass) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    bit_cnt_d = bit_cnt_q;
    k_d       = k_q;
    n_d       = n_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (n < NW'(2)) begin
            result_d = (n == NW'(1)) ? WIDTH'(1) : '0;
          end else begin
            a_d       = '0;
            b_d       = WIDTH'(1);
            bit_cnt_d = '0;
            k_d       = NW'(1);
            n_d       = n;
          end
        end
      end
      ST_ADD: begin
        // A takes B's outgoing bit, B takes the fresh sum bit at the MSB end.
        a_d       = {b_q[0], a_q[WIDTH-1:1]};
        b_d       = {fa_sum, b_q[WIDTH-1:1]};
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
        if (last_bit) begin
          ovf_d = ovf_q | fib_maj(a_q[0], b_q[0], fa_carry);
          if (last_pass) begin
            result_d = {fa_sum, b_q[WIDTH-1:1]};
          end else begin
            k_d = k_q + NW'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_fib_serial_engine.sv
// Scoreboard bench for fib_serial_engine: stimulus pushes expected F(n),
// overflow and done cycle; a negedge monitor pops and compares on done.
module tb_fib_serial_engine;

  localparam int W  = 8;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          CLR = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] n = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          ovf;

  typedef struct {
    int res;
    int ov;
    int start_cyc;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   assertions = 0;
  int   failures = 0;
  int   last_res = 0;
  int   last_ovf = 0;
  bit   mon_en = 1'b0;

  fib_serial_engine #(.WIDTH(W), .NW(NB)) dut (
    .clk    (clk),
    .CLR    (CLR),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: iterate the Fibonacci recurrence with modular wrap, noting
  // whether any step's true sum reached 2^W.
  function automatic exp_t fibModel(input int nv, input int c0);
    exp_t e;
    int   fa, fb, s;
    fa = 0;
    fb = 1;
    e.ov = 0;
    if (nv == 0) begin
      e.res = 0;
    end else begin
      for (int i = 2; i <= nv; i++) begin
        s = fa + fb;
        if (s >= (1 << W)) e.ov = 1;
        fa = fb;
        fb = s % (1 << W);
      end
      e.res = fb;
    end
    e.start_cyc = c0;
    e.done_cyc  = c0 + ((nv <= 1) ? 1 : (nv - 1) * W + 1);
    return e;
  endfunction

  task automatic applyStimulus(input int nv, input bit accept);
    start = 1'b1;
    n     = NB'(nv);
    if (accept) sb.push_back(fibModel(nv, cyc));
    tick();
    start = 1'b0;
    n     = NB'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int left;
    left = budget;
    while (sb.size() > 0 && left > 0) begin
      tick();
      left--;
    end
    if (sb.size() > 0) begin
      checkOutput("done_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  task automatic clearRun();
    sb.delete();
    last_res = 0;
    last_ovf = 0;
  endtask

  // Monitor: busy tracks the outstanding request, result only changes on
  // done, and each done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      checkOutput("busy", int'(busy), int'(sb.size() > 0 && cyc > sb[0].start_cyc));
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", cyc - e.start_cyc, e.done_cyc - e.start_cyc);
          checkOutput("result", int'(result), e.res);
          checkOutput("ovf", int'(ovf), e.ov);
          last_res = e.res;
          last_ovf = e.ov;
        end
      end else begin
        checkOutput("result_hold", int'(result), last_res);
        if (sb.size() == 0) checkOutput("ovf_hold", int'(ovf), last_ovf);
        if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
          checkOutput("done_missing", int'(done), 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int nv, lat, off;

    CLR = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_result", int'(result), 0);
      checkOutput("reset_ovf", int'(ovf), 0);
    end
    CLR = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick();

    $display("[TB] n=10 with hold check");
    applyStimulus(10, 1'b1);
    waitDone(200);
    repeat (10) tick();
    checkOutput("result_10_later", int'(result), 55);

    $display("[TB] n=0, n=1, n=13, n=14");
    applyStimulus(0, 1'b1);
    waitDone(10);
    applyStimulus(1, 1'b1);
    waitDone(10);
    applyStimulus(13, 1'b1);
    waitDone(200);
    applyStimulus(14, 1'b1);
    waitDone(200);

    $display("[TB] start while busy is ignored");
    applyStimulus(10, 1'b1);
    repeat (19) tick();
    applyStimulus(3, 1'b0);
    waitDone(200);

    $display("[TB] CLR aborts a run");
    applyStimulus(12, 1'b1);
    repeat (29) tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    clearRun();
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_result", int'(result), 0);
    checkOutput("abort_ovf", int'(ovf), 0);
    repeat (100) tick();
    applyStimulus(5, 1'b1);
    waitDone(100);

    $display("[TB] start and CLR together");
    CLR = 1'b1;
    applyStimulus(7, 1'b0);
    CLR = 1'b0;
    clearRun();
    checkOutput("startclr_busy", int'(busy), 0);
    repeat (10) tick();

    $display("[TB] randomized requests");
    for (int it = 0; it < 12; it++) begin
      nv = $urandom_range(0, 20);
      lat = (nv <= 1) ? 1 : (nv - 1) * W + 1;
      applyStimulus(nv, 1'b1);
      if (nv >= 2 && $urandom_range(0, 1) == 1) begin
        off = $urandom_range(1, lat - 1);
        repeat (off - 1) tick();
        applyStimulus(int'($urandom_range(0, 31)), 1'b0);
      end
      waitDone(300);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
